// File: rtl/mem_port_arbiter.sv
// Two-master arbiter (M0 = CPU data, M1 = DMA/loader) in front of one simple_ram port.
// Define ARB_LOCK_EN to add m0_lock/m1_lock and the LOCKED ownership state.

module mem_port_arbiter_rsp #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd_acc,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= rd_acc;
         if (rd_acc) rdata <= mem_rdata;
      end
   end
endmodule

module mem_port_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RR_EN      = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   output logic                  m0_ready,
   output logic                  m0_rvalid,
   output logic [DATA_W-1:0]     m0_rdata,
   input  logic                  m1_req,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   output logic                  m1_ready,
   output logic                  m1_rvalid,
   output logic [DATA_W-1:0]     m1_rdata,
`ifdef ARB_LOCK_EN
   input  logic                  m0_lock,
   input  logic                  m1_lock,
`endif
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic [DATA_W/8-1:0]   mem_wenable,
   input  logic [DATA_W-1:0]     mem_rdata
);
   localparam int STRB_W = DATA_W / 8;
   localparam int CNT_W  = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   typedef struct packed {
      logic              req;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [STRB_W-1:0] wstrb;
   } port_req_t;

   typedef enum logic {ARB, LOCKED} state_t;

   port_req_t [1:0]        preq;
   logic [1:0]             gnt, arb_gnt, rd_acc, rvalid;
   logic [1:0][DATA_W-1:0] rdata;
   state_t                 state, state_nxt;
   logic                   last_grant;   // 0 = M0, 1 = M1
   logic [CNT_W-1:0]       starve_cnt;
   logic                   tie_m1;

   assign preq[0] = '{req: m0_req, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
   assign preq[1] = '{req: m1_req, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};

`ifdef ARB_LOCK_EN
   logic [1:0] lock;
   logic       owner, owner_nxt;
   assign lock = {m1_lock, m0_lock};
`endif

   // Tie-break: round-robin favours whoever did not win last; fixed priority gives M1 a turn once starved.
   assign tie_m1 = (RR_EN != 0) ? !last_grant : (starve_cnt == CNT_MAX);

   always_comb begin
      arb_gnt = 2'b00;
      if (preq[0].req && preq[1].req) arb_gnt = tie_m1 ? 2'b10 : 2'b01;
      else                            arb_gnt = {preq[1].req, preq[0].req};
   end

   always_comb begin
      state_nxt = state;
      gnt       = '0;
`ifdef ARB_LOCK_EN
      owner_nxt = owner;
`endif
      if (rst_n) begin
         case (state)
            LOCKED: begin
`ifdef ARB_LOCK_EN
               // owner keeps the port while it asks; a dropped req is the release cycle
               if (preq[owner].req) gnt[owner] = 1'b1;
               else                 gnt = arb_gnt;
`else
               gnt = arb_gnt;
`endif
            end
            default: gnt = arb_gnt;
         endcase
`ifdef ARB_LOCK_EN
         state_nxt = (|(gnt & lock)) ? LOCKED : ARB;
         if (|gnt) owner_nxt = gnt[1];
`else
         state_nxt = ARB;
`endif
      end
   end

   always_comb begin
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_wenable = '0;
      for (int i = 0; i < 2; i++) begin
         if (gnt[i]) begin
            mem_addr    = preq[i].addr;
            mem_wdata   = preq[i].wdata;
            mem_wenable = preq[i].wstrb;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB;
         last_grant <= 1'b1;
         starve_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (|gnt) last_grant <= gnt[1];
         if (gnt[1])
            starve_cnt <= '0;
         else if (preq[1].req && state != LOCKED && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
      end
   end

`ifdef ARB_LOCK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) owner <= 1'b0;
      else        owner <= owner_nxt;
   end
`endif

   for (genvar g = 0; g < 2; g++) begin : g_rsp
      assign rd_acc[g] = gnt[g] && (preq[g].wstrb == '0);
      mem_port_arbiter_rsp #(.DATA_W(DATA_W)) u_rsp (
         .clk       (clk),
         .rst_n     (rst_n),
         .rd_acc    (rd_acc[g]),
         .mem_rdata (mem_rdata),
         .rvalid    (rvalid[g]),
         .rdata     (rdata[g])
      );
   end

   assign m0_ready  = gnt[0];
   assign m1_ready  = gnt[1];
   assign m0_rvalid = rvalid[0];
   assign m1_rvalid = rvalid[1];
   assign m0_rdata  = rdata[0];
   assign m1_rdata  = rdata[1];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench: round-robin (k=0) and fixed-priority (k=1) arbiters driven side by side, each with its own RAM.
module tb_mem_port_arbiter;
   logic clk = 1'b0, rst_n = 1'b0, load = 1'b1;
   always #5 clk = ~clk;

   logic        m0_req = 1'b0, m1_req = 1'b0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
`ifdef ARB_LOCK_EN
   logic        m0_lock = 1'b0, m1_lock = 1'b0;
`endif
   logic [1:0]  m0_ready_k, m1_ready_k, m0_rvalid_k, m1_rvalid_k;
   logic [31:0] m0_rdata_k [2], m1_rdata_k [2], mem_addr_k [2], mem_wdata_k [2], mem_rdata_k [2];
   logic [3:0]  mem_wen_k [2];
   logic [31:0] ram [2][64];

   int checks = 0, errors = 0;
   int glog0[$], glog1[$];

   // model state
   logic [31:0] mdl [2][64];
   int          m_last [2]   = '{1, 1};
   int          m_starve [2] = '{0, 0};
   int          m_lock [2]   = '{-1, -1};
   logic [1:0]  m_rv [2]     = '{2'b00, 2'b00};
   logic [31:0] m_rd [2][2];

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(1), .STARVE_MAX(4)) dut_rr (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready_k[0]), .m0_rvalid(m0_rvalid_k[0]), .m0_rdata(m0_rdata_k[0]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready_k[0]), .m1_rvalid(m1_rvalid_k[0]), .m1_rdata(m1_rdata_k[0]),
`ifdef ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .mem_addr(mem_addr_k[0]), .mem_wdata(mem_wdata_k[0]), .mem_wenable(mem_wen_k[0]),
      .mem_rdata(mem_rdata_k[0]));

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RR_EN(0), .STARVE_MAX(4)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_ready(m0_ready_k[1]), .m0_rvalid(m0_rvalid_k[1]), .m0_rdata(m0_rdata_k[1]),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_ready(m1_ready_k[1]), .m1_rvalid(m1_rvalid_k[1]), .m1_rdata(m1_rdata_k[1]),
`ifdef ARB_LOCK_EN
      .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
      .mem_addr(mem_addr_k[1]), .mem_wdata(mem_wdata_k[1]), .mem_wenable(mem_wen_k[1]),
      .mem_rdata(mem_rdata_k[1]));

   assign mem_rdata_k[0] = ram[0][mem_addr_k[0][7:2]];
   assign mem_rdata_k[1] = ram[1][mem_addr_k[1][7:2]];

   function automatic logic [31:0] init_word(int i);
      case (i)
         4:       return 32'hDEADBEEF;
         8:       return 32'hCAFEBABE;
         12:      return 32'h11223344;
         default: return {8'hA5, 16'h0, 8'(i)};
      endcase
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 64; i++) begin
            if (load) ram[k][i] <= init_word(i);
            else if (mem_addr_k[k][7:2] == 6'(i))
               for (int b = 0; b < 4; b++)
                  if (mem_wen_k[k][b]) ram[k][i][8*b +: 8] <= mem_wdata_k[k][8*b +: 8];
         end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] qpack(input int q[$]);
      logic [63:0] v;
      v = '0;
      foreach (q[i]) v = (v << 4) | 64'(q[i]);
      return v;
   endfunction

   // Whole-cycle model: who may win under the arbitration rules, then what that implies for next cycle.
   task automatic model_cycle(input int k);
      logic [1:0]  rq, lk, rdy, nrv;
      logic [31:0] ad [2], wd [2], ea, ed;
      logic [3:0]  st [2], ew;
      int          w;
      bit          frozen;
      rq = {m1_req, m0_req};
      lk = '0;
`ifdef ARB_LOCK_EN
      lk = {m1_lock, m0_lock};
`endif
      ad[0] = m0_addr; ad[1] = m1_addr;
      wd[0] = m0_wdata; wd[1] = m1_wdata;
      st[0] = m0_wstrb; st[1] = m1_wstrb;
      if (!rst_n) begin
         m_last[k] = 1; m_starve[k] = 0; m_lock[k] = -1; m_rv[k] = '0;
         m_rd[k][0] = '0; m_rd[k][1] = '0;
      end
      w = -1;
      if (rst_n) begin
         if (m_lock[k] >= 0 && rq[m_lock[k]]) w = m_lock[k];
         else if (rq == 2'b01) w = 0;
         else if (rq == 2'b10) w = 1;
         else if (rq == 2'b11) w = (k == 0) ? 1 - m_last[k] : ((m_starve[k] == 4) ? 1 : 0);
      end
      rdy = '0; ea = '0; ed = '0; ew = '0;
      if (w >= 0) begin rdy[w] = 1'b1; ea = ad[w]; ed = wd[w]; ew = st[w]; end
      chk($sformatf("k%0d ready", k), 64'({m1_ready_k[k], m0_ready_k[k]}), 64'(rdy));
      chk($sformatf("k%0d mem_addr", k), 64'(mem_addr_k[k]), 64'(ea));
      chk($sformatf("k%0d mem_wdata", k), 64'(mem_wdata_k[k]), 64'(ed));
      chk($sformatf("k%0d mem_wenable", k), 64'(mem_wen_k[k]), 64'(ew));
      chk($sformatf("k%0d rvalid", k), 64'({m1_rvalid_k[k], m0_rvalid_k[k]}), 64'(m_rv[k]));
      chk($sformatf("k%0d m0_rdata", k), 64'(m0_rdata_k[k]), 64'(m_rd[k][0]));
      chk($sformatf("k%0d m1_rdata", k), 64'(m1_rdata_k[k]), 64'(m_rd[k][1]));
      if (rst_n) begin
         frozen = (m_lock[k] >= 0);
         nrv = '0;
         if (w >= 0) begin
            m_last[k] = w;
            if (st[w] == 4'b0) begin
               nrv[w] = 1'b1;
               m_rd[k][w] = mdl[k][ad[w][7:2]];
            end else begin
               for (int b = 0; b < 4; b++)
                  if (st[w][b]) mdl[k][ad[w][7:2]][8*b +: 8] = wd[w][8*b +: 8];
            end
            m_lock[k] = lk[w] ? w : -1;
         end else begin
            m_lock[k] = -1;
         end
         if (!frozen) begin
            if (w == 1) m_starve[k] = 0;
            else if (rq[1] && m_starve[k] < 4) m_starve[k]++;
         end
         m_rv[k] = nrv;
      end
   endtask

   always @(negedge clk) begin
      if (load)
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) mdl[k][i] = init_word(i);
      if (m0_ready_k[0]) glog0.push_back(0);
      if (m1_ready_k[0]) glog0.push_back(1);
      if (m0_ready_k[1]) glog1.push_back(0);
      if (m1_ready_k[1]) glog1.push_back(1);
      model_cycle(0);
      model_cycle(1);
   end

   task automatic step(); @(posedge clk); #1; endtask
   task automatic idle(); m0_req = 1'b0; m1_req = 1'b0; m0_wstrb = '0; m1_wstrb = '0; endtask
   task automatic rd0(input logic [31:0] a); m0_req = 1'b1; m0_addr = a; m0_wdata = '0; m0_wstrb = '0; endtask
   task automatic rd1(input logic [31:0] a); m1_req = 1'b1; m1_addr = a; m1_wdata = '0; m1_wstrb = '0; endtask
   task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m0_req = 1'b1; m0_addr = a; m0_wdata = d; m0_wstrb = s;
   endtask
   task automatic wr1(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      m1_req = 1'b1; m1_addr = a; m1_wdata = d; m1_wstrb = s;
   endtask
   task automatic clr_log(); glog0.delete(); glog1.delete(); endtask

   initial begin
      // reset with a request pending: nothing may be granted
      rd0(32'h10);
      step(); step(); load = 1'b0;
      #2;
      chk("rst_ready", 64'({m0_ready_k, m1_ready_k}), 64'h0);
      chk("rst_rvalid", 64'({m0_rvalid_k, m1_rvalid_k}), 64'h0);
      chk("rst_rdata", 64'(m0_rdata_k[0]), 64'h0);
      step(); idle(); rst_n = 1'b1;

      // single M0 read
      rd0(32'h10); #2;
      chk("t1_ready", 64'(m0_ready_k), 64'h3);
      chk("t1_wen", 64'(mem_wen_k[0]), 64'h0);
      step(); idle();
      chk("t1_rvalid", 64'(m0_rvalid_k), 64'h3);
      chk("t1_rdata_rr", 64'(m0_rdata_k[0]), 64'hDEADBEEF);
      chk("t1_rdata_fp", 64'(m0_rdata_k[1]), 64'hDEADBEEF);
      step();
      chk("t1_rvalid_drop", 64'(m0_rvalid_k), 64'h0);
      chk("t1_rdata_hold", 64'(m0_rdata_k[0]), 64'hDEADBEEF);

      // M1 alone so round-robin last_grant is M1 again
      rd1(32'h0C); step(); idle(); step();

      // both read for 4 cycles
      clr_log();
      rd0(32'h04); rd1(32'h08);
      repeat (4) step();
      idle();
      chk("t2_rr_last_rvalid", 64'({m1_rvalid_k[0], m0_rvalid_k[0]}), 64'h2);
      chk("t2_rr_order", qpack(glog0), 64'h0101);
      chk("t2_rr_len", 64'(glog0.size()), 64'd4);
      chk("t2_fp_order", qpack(glog1), 64'h0000);
      chk("t2_fp_len", 64'(glog1.size()), 64'd4);
      step();

      // M1 partial write, then M0 reads it back
      wr1(32'h20, 32'h12345678, 4'b0011); #2;
      chk("t3_m1_ready", 64'(m1_ready_k), 64'h3);
      chk("t3_wen_rr", 64'(mem_wen_k[0]), 64'h3);
      chk("t3_wen_fp", 64'(mem_wen_k[1]), 64'h3);
      step(); idle(); #2;
      chk("t3_wen_off", 64'(mem_wen_k[0]), 64'h0);
      chk("t3_no_rvalid", 64'(m1_rvalid_k), 64'h0);
      step();
      rd0(32'h20); step(); idle();
      chk("t3_rdata_rr", 64'(m0_rdata_k[0]), 64'hCAFE5678);
      chk("t3_rdata_fp", 64'(m0_rdata_k[1]), 64'hCAFE5678);

      // continuous contention, 10 cycles
      clr_log();
      rd0(32'h00); rd1(32'h04);
      repeat (10) step();
      idle();
      chk("t4_fp_order", qpack(glog1), 64'h0000100001);
      chk("t4_fp_len", 64'(glog1.size()), 64'd10);
      chk("t4_rr_order", qpack(glog0), 64'h1010101010);
      step();

      // reset lands on an M0 write accept
      wr0(32'h30, 32'hFFFFFFFF, 4'hF); rst_n = 1'b0; #2;
      chk("t5_ready", 64'({m0_ready_k, m1_ready_k}), 64'h0);
      chk("t5_wen", 64'(mem_wen_k[0]), 64'h0);
      step();
      chk("t5_rvalid", 64'({m0_rvalid_k, m1_rvalid_k}), 64'h0);
      step();
      clr_log();
      rst_n = 1'b1; rd0(32'h30); rd1(32'h00);
      step();
      chk("t5_rvalid_after", 64'(m0_rvalid_k), 64'h3);
      chk("t5_rdata_rr", 64'(m0_rdata_k[0]), 64'h11223344);
      chk("t5_rdata_fp", 64'(m0_rdata_k[1]), 64'h11223344);
      step(); idle();
      chk("t5_rr_order", qpack(glog0), 64'h01);
      chk("t5_rr_len", 64'(glog0.size()), 64'd2);
      chk("t5_fp_order", qpack(glog1), 64'h00);
      chk("t5_ram_rr", 64'(ram[0][12]), 64'h11223344);
      chk("t5_ram_fp", 64'(ram[1][12]), 64'h11223344);
      step();

`ifdef ARB_LOCK_EN
      // M1 locked reads, M0 requesting throughout
      rd0(32'h00); step(); idle(); step();
      clr_log();
      rd0(32'h04); rd1(32'h08); m1_lock = 1'b1;
      repeat (3) step();
      m1_lock = 1'b0;
      step();
      m1_req = 1'b0;
      step();
      idle(); step();
      chk("t6_rr_order", qpack(glog0), 64'h11110);
      chk("t6_rr_len", 64'(glog0.size()), 64'd5);
      chk("t6_fp_order", qpack(glog1), 64'h00110);
`endif

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
